// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (one quotient bit per clock); SEQ_DIVIDER_SIGNED_EN selects two's-complement operands.
// Latency: WIDTH+1 edges from accept to out_valid (WIDTH+2 signed), 1 edge for divide by zero.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, with no operand overlap.
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             quot_zero_r
);

  // FIX is only reachable in the signed build, where it applies the sign correction
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] shreg_q;   // dividend bits shift out at the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dvs_q;     // divisor magnitude
  logic [WIDTH:0]   rem_q;     // partial remainder
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             last;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             neg_q_q;   // operand signs differ
  logic             neg_r_q;   // dividend was negative
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  // The final iteration is the one that takes the counter from 1 to 0
  assign last      = (state_q == CALC) && (cnt_q == CNT_W'(1));

  // Operand magnitudes fed into the unsigned core
  always_comb begin
    mag_a = dividend;
    mag_b = divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (dividend[WIDTH-1]) mag_a = -dividend;
    if (divisor[WIDTH-1])  mag_b = -divisor;
`endif
  end

  // One restoring shift-subtract step
  always_comb begin
    shifted  = {rem_q[WIDTH-1:0], shreg_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_q};
    // A set top bit of the old remainder means the shifted value already exceeds any divisor
    qbit     = rem_q[WIDTH] | ~trial[WIDTH];
    rem_step = qbit ? trial : shifted;
    q_step   = {shreg_q[WIDTH-2:0], qbit};
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  // Sign correction: quotient truncates toward zero, remainder follows the dividend
  always_comb begin
    q_fix = neg_q_q ? -shreg_q : shreg_q;
    r_fix = neg_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (divisor == '0) ? DONE : CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
      CALC: if (last) state_d = FIX;
`else
      CALC: if (last) state_d = DONE;
`endif
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Iteration datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      quot_zero_r <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q <= mag_a;
            dvs_q   <= mag_b;
            rem_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_q <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              quot_zero_r <= 1'b0;
            end
          end
        end
        CALC: begin
          shreg_q <= q_step;
          rem_q   <= rem_step;
          cnt_q   <= cnt_q - CNT_W'(1);
`ifndef SEQ_DIVIDER_SIGNED_EN
          if (last) begin
            quotient    <= q_step;
            remainder   <= rem_step[WIDTH-1:0];
            div_by_zero <= 1'b0;
            quot_zero_r <= (q_step == '0);
          end
`endif
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= 1'b0;
          quot_zero_r <= (q_fix == '0);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus hand sequences for stall and reset.
// Latency counts clock edges from the accepting edge (inclusive) to out_valid.
// Backpressure is exercised by holding out_ready low in DONE.
module tb_seq_divider;

  localparam int WIDTH = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int LAT = WIDTH + 2;
`else
  localparam int LAT = WIDTH + 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             quot_zero_r;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       qz;
    int         lat;
  } vec_t;

  vec_t tv[10];

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .quot_zero_r(quot_zero_r)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                              input logic [7:0] r, input logic dbz, input logic qz, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dbz; v.qz = qz; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present operands, wait for acceptance, then count edges until out_valid
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat, output int rdy_err);
    int guard;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    rdy_err  = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_err++;
      @(posedge clk); #1; lat++;
    end
  endtask

  initial begin
    int lat, rdy_err;
    logic [7:0] exp_q4, exp_r4;

`ifdef SEQ_DIVIDER_SIGNED_EN
    tv[0] = mk(8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, 1'b0, LAT);  // -100 / 7
    tv[1] = mk(8'd100, 8'hF9, 8'hF2, 8'd2,  1'b0, 1'b0, LAT); // 100 / -7
    tv[2] = mk(8'h9C, 8'hF9, 8'd14, 8'hFE, 1'b0, 1'b0, LAT);  // -100 / -7
    tv[3] = mk(8'h80, 8'd1,  8'h80, 8'd0,  1'b0, 1'b0, LAT);  // -128 / 1
    tv[4] = mk(8'd37, 8'd0,  8'hFF, 8'd37, 1'b1, 1'b0, 1);
    tv[5] = mk(8'd5,  8'd9,  8'd0,  8'd5,  1'b0, 1'b1, LAT);
    tv[6] = mk(8'h80, 8'hFF, 8'h80, 8'd0,  1'b0, 1'b0, LAT);  // -128 / -1 wraps
    tv[7] = mk(8'd7,  8'hFE, 8'hFD, 8'd1,  1'b0, 1'b0, LAT);  // 7 / -2
    tv[8] = mk(8'd0,  8'd5,  8'd0,  8'd0,  1'b0, 1'b1, LAT);
    tv[9] = mk(8'hF9, 8'd0,  8'hFF, 8'hF9, 1'b1, 1'b0, 1);    // -7 / 0
    exp_q4 = 8'hEE; exp_r4 = 8'hFE;                           // -56 / 3
`else
    tv[0] = mk(8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 1'b0, LAT);
    tv[1] = mk(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 1'b0, LAT);
    tv[2] = mk(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 1'b1, LAT);
    tv[3] = mk(8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 1'b0, 1);
    tv[4] = mk(8'd200, 8'd3,   8'd66,  8'd2,  1'b0, 1'b0, LAT);
    tv[5] = mk(8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 1'b1, LAT);
    tv[6] = mk(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 1'b0, LAT);
    tv[7] = mk(8'd128, 8'd16,  8'd8,   8'd0,  1'b0, 1'b0, LAT);
    tv[8] = mk(8'd254, 8'd17,  8'd14,  8'd16, 1'b0, 1'b0, LAT);
    tv[9] = mk(8'd0,   8'd0,   8'hFF,  8'd0,  1'b1, 1'b0, 1);
    exp_q4 = 8'd66; exp_r4 = 8'd2;
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_div_by_zero", div_by_zero, 0);
    chk("rst_quot_zero", quot_zero_r, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Table vectors, issued back to back with out_ready held high
    for (int i = 0; i < 10; i++) begin
      run_op(tv[i].a, tv[i].b, lat, rdy_err);
      chk($sformatf("v%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("v%0d_quotient", i), quotient, tv[i].q);
      chk($sformatf("v%0d_remainder", i), remainder, tv[i].r);
      chk($sformatf("v%0d_div_by_zero", i), div_by_zero, tv[i].dbz);
      chk($sformatf("v%0d_quot_zero", i), quot_zero_r, tv[i].qz);
      chk($sformatf("v%0d_in_ready_busy", i), rdy_err, 0);
    end

    // Stall in DONE: result held, new operands ignored
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(8'd200, 8'd3, lat, rdy_err);
    chk("stall_latency", lat, LAT);
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin
        in_valid = 1'b1; dividend = 8'd9; divisor = 8'd2;
      end
      chk($sformatf("stall%0d_out_valid", c), out_valid, 1);
      chk($sformatf("stall%0d_in_ready", c), in_ready, 0);
      chk($sformatf("stall%0d_quotient", c), quotient, exp_q4);
      chk($sformatf("stall%0d_remainder", c), remainder, exp_r4);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_in_ready", in_ready, 1);
    chk("stall_release_out_valid", out_valid, 0);
    chk("stall_release_quotient_held", quotient, exp_q4);

    // Asynchronous reset during the 4th CALC cycle
    in_valid = 1'b1; dividend = 8'd90; divisor = 8'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("midrst_busy", in_ready, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle_after", in_ready, 1);
    chk("midrst_no_result", out_valid, 0);
    run_op(8'd90, 8'd4, lat, rdy_err);
    chk("after_rst_latency", lat, LAT);
    chk("after_rst_quotient", quotient, 22);
    chk("after_rst_remainder", remainder, 2);
    chk("after_rst_div_by_zero", div_by_zero, 0);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
